// File: rtl/hack_vga_scanout.sv
// ============================================================================
// Module   : hack_vga_scanout
// Purpose  : VGA scanout of the Hack 512x256 screen buffer, centred in 640x480.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_vga_scanout #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int X_OFF     = 64,
    parameter int Y_OFF     = 112
) (
    input  logic        clock,
    input  logic        reset,
    output logic [12:0] vga_word_addr,
    input  logic [15:0] vga_word,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic        vga_pixel,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int HW      = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int VW      = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;

    localparam logic [DIV_W-1:0] C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]    C_H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    C_V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]    C_H_VIS     = HW'(H_VISIBLE);
    localparam logic [VW-1:0]    C_V_VIS     = VW'(V_VISIBLE);
    localparam logic [HW-1:0]    C_HS_START  = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0]    C_HS_END    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0]    C_VS_START  = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0]    C_VS_END    = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [HW-1:0]    C_X_OFF     = HW'(X_OFF);
    localparam logic [VW-1:0]    C_Y_OFF     = VW'(Y_OFF);
    localparam logic [HW-1:0]    C_IMG_W     = HW'(512);
    localparam logic [VW-1:0]    C_IMG_H     = VW'(256);

    logic [DIV_W-1:0] div_q, div_d;
    logic [HW-1:0]    h_q, h_d;
    logic [VW-1:0]    v_q, v_d;

    // Stage 1: address and per-pixel attributes
    logic [12:0]      addr_q, addr_d;
    logic [3:0]       bit_s1_q, bit_s1_d;
    logic             in_img_s1_q, in_img_s1_d;
    logic             de_s1_q, de_s1_d;
    logic             hs_s1_q, hs_s1_d;
    logic             vs_s1_q, vs_s1_d;
    logic             first_s1_q, first_s1_d;

    // Stage 2: output registers
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             pixel_q, pixel_d;
    logic             frame_q, frame_d;

    logic             w_tick;
    logic [HW-1:0]    w_xi;
    logic [VW-1:0]    w_yi;
    logic             w_de;
    logic             w_in_img;

    assign w_tick = (div_q == C_DIV_LAST);
    assign w_xi   = h_q - C_X_OFF;
    assign w_yi   = v_q - C_Y_OFF;
    assign w_de   = (h_q < C_H_VIS) && (v_q < C_V_VIS);
    // Gated with de so the image can never leak into blanking, whatever the timing.
    assign w_in_img = w_de && (h_q >= C_X_OFF) && (w_xi < C_IMG_W)
                           && (v_q >= C_Y_OFF) && (w_yi < C_IMG_H);

    always_comb begin
        div_d       = w_tick ? '0 : div_q + 1'b1;
        h_d         = h_q;
        v_d         = v_q;
        addr_d      = addr_q;
        bit_s1_d    = bit_s1_q;
        in_img_s1_d = in_img_s1_q;
        de_s1_d     = de_s1_q;
        hs_s1_d     = hs_s1_q;
        vs_s1_d     = vs_s1_q;
        first_s1_d  = first_s1_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        de_d        = de_q;
        pixel_d     = pixel_q;
        frame_d     = 1'b0;
        if (w_tick) begin
            h_d = (h_q == C_H_LAST) ? '0 : h_q + 1'b1;
            if (h_q == C_H_LAST) begin
                v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
            end
            if (w_in_img) begin
                addr_d = {w_yi[7:0], w_xi[8:4]};
            end
            bit_s1_d    = w_xi[3:0];
            in_img_s1_d = w_in_img;
            de_s1_d     = w_de;
            hs_s1_d     = (h_q >= C_HS_START) && (h_q < C_HS_END);
            vs_s1_d     = (v_q >= C_VS_START) && (v_q < C_VS_END);
            first_s1_d  = (h_q == '0) && (v_q == '0);
            // Hack convention: a set bit is black, bit 0 is the leftmost pixel.
            hsync_d     = ~hs_s1_q;
            vsync_d     = ~vs_s1_q;
            de_d        = de_s1_q;
            pixel_d     = in_img_s1_q & ~vga_word[bit_s1_q];
            frame_d     = first_s1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            addr_q      <= '0;
            bit_s1_q    <= '0;
            in_img_s1_q <= 1'b0;
            de_s1_q     <= 1'b0;
            hs_s1_q     <= 1'b0;
            vs_s1_q     <= 1'b0;
            first_s1_q  <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            de_q        <= 1'b0;
            pixel_q     <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            div_q       <= div_d;
            h_q         <= h_d;
            v_q         <= v_d;
            addr_q      <= addr_d;
            bit_s1_q    <= bit_s1_d;
            in_img_s1_q <= in_img_s1_d;
            de_s1_q     <= de_s1_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            first_s1_q  <= first_s1_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            pixel_q     <= pixel_d;
            frame_q     <= frame_d;
        end
    end

    assign vga_word_addr = addr_q;
    assign vga_hsync     = hsync_q;
    assign vga_vsync     = vsync_q;
    assign vga_de        = de_q;
    assign vga_pixel     = pixel_q;
    assign frame_start   = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_hack_vga_scanout.sv
// ============================================================================
// Module   : tb_hack_vga_scanout
// Purpose  : Randomised-memory bench comparing every clock against a raster model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hack_vga_scanout;

    // Compact raster so whole frames fit in the cycle budget.
    localparam int CLK_DIV = 2;
    localparam int HV = 560, HF = 8, HS = 16, HB = 8;
    localparam int VV = 20,  VF = 2, VS = 3,  VB = 2;
    localparam int XO = 24,  YO = 4;
    localparam int H_TOT = HV + HF + HS + HB;
    localparam int V_TOT = VV + VF + VS + VB;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] vga_word_addr;
    logic [15:0] vga_word;
    logic        vga_hsync, vga_vsync, vga_de, vga_pixel, frame_start;

    logic [15:0] mem [0:8191];

    int          n_checks = 0;
    int          n_errors = 0;
    int          c = 0;
    logic [12:0] exp_addr = '0;

    always #5 clk = ~clk;

    always @(posedge clk) vga_word <= mem[vga_word_addr];

    hack_vga_scanout #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .X_OFF(XO), .Y_OFF(YO)
    ) dut (
        .clock         (clk),
        .reset         (rst),
        .vga_word_addr (vga_word_addr),
        .vga_word      (vga_word),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_de        (vga_de),
        .vga_pixel     (vga_pixel),
        .frame_start   (frame_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (c=%0d t=%0t)", tag, obs, exp, c, $time);
        end
    endtask

    function automatic logic in_image(input int h, input int v);
        return (h < HV) && (v < VV) && (h >= XO) && (h < XO + 512) && (v >= YO) && (v < YO + 256);
    endfunction

    // One clock: advance the model at the edge, compare outputs half a period later.
    task automatic step();
        int k, p, h, v, q;
        logic [15:0] word;
        logic e_hs, e_vs, e_de, e_pix, e_fs;
        @(posedge clk);
        if (rst) begin
            c        = 0;
            exp_addr = '0;
        end else begin
            c++;
            if (c % CLK_DIV == 0) begin
                q = c / CLK_DIV - 1;
                h = q % H_TOT;
                v = (q / H_TOT) % V_TOT;
                if (in_image(h, v)) exp_addr = 13'((v - YO) * 32 + (h - XO) / 16);
            end
        end
        @(negedge clk);
        k = c / CLK_DIV;
        if (k < 2) begin
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_pix = 1'b0; e_fs = 1'b0;
        end else begin
            p     = k - 2;
            h     = p % H_TOT;
            v     = (p / H_TOT) % V_TOT;
            e_de  = (h < HV) && (v < VV);
            e_hs  = !((h >= HV + HF) && (h < HV + HF + HS));
            e_vs  = !((v >= VV + VF) && (v < VV + VF + VS));
            e_pix = 1'b0;
            if (in_image(h, v)) begin
                word  = mem[(v - YO) * 32 + (h - XO) / 16];
                e_pix = !word[(h - XO) % 16];
            end
            e_fs  = (c % CLK_DIV == 0) && (p % FRAME == 0);
        end
        check_eq("hsync", vga_hsync, e_hs);
        check_eq("vsync", vga_vsync, e_vs);
        check_eq("de", vga_de, e_de);
        check_eq("pixel", vga_pixel, e_pix);
        check_eq("frame_start", frame_start, e_fs);
        check_eq("addr", vga_word_addr, exp_addr);
    endtask

    initial begin
        int r;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        // Leftmost and rightmost bit of the first two words set: black at those pixels only.
        mem[0] = 16'h0001;
        mem[1] = 16'h8000;
        mem[2] = 16'h0000;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (FRAME * CLK_DIV + 2 * H_TOT * CLK_DIV) step();

        r = $urandom_range(200, FRAME * CLK_DIV / 2);
        repeat (r) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3 * H_TOT * CLK_DIV) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hack_vga_scanout.md
Name: hack_vga_scanout

Overview:
Reader end of the screen buffer's second (video) port. Walks VGA 640x480@60 timing and issues word addresses into the 8K-word screen buffer. It serialises each returned 16-bit word into 16 pixels and drives sync, display-enable and a 1-bit pixel. The 512x256 Hack image is centred in the 640x480 raster with a black border.

Parameters:
CLK_DIV, 2, system clocks per pixel tick; legal range is 2 or more (1 is not supported).
H_VISIBLE, 640, visible pixels per line.
H_FRONT, 16, horizontal front porch in pixels.
H_SYNC, 96, hsync pulse width in pixels.
H_BACK, 48, horizontal back porch in pixels; line total is 800.
V_VISIBLE, 480, visible lines.
V_FRONT, 10, vertical front porch in lines.
V_SYNC, 2, vsync width in lines.
V_BACK, 33, vertical back porch in lines; frame total is 525.
X_OFF, 64, first image column in the raster.
Y_OFF, 112, first image line in the raster.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
vga_word_addr  output  13  screen-buffer read address.
vga_word  input  16  screen-buffer read data, valid one clock after vga_word_addr.
vga_hsync  output  1  horizontal sync, active low.
vga_vsync  output  1  vertical sync, active low.
vga_de  output  1  high inside the visible 640x480 area.
vga_pixel  output  1  1 = white, 0 = black.
frame_start  output  1  one-clock pulse when the output stage is at raster (0,0).

Behaviour:
- One clock, synchronous active-high reset.
- Tick divider: counts 0..CLK_DIV-1 and asserts a pixel tick on the last count. All pipeline state advances only on ticks.
- Counters h (0..799) and v (0..524):
  - h increments each tick and wraps 799->0.
  - v increments when h wraps, and wraps 524->0.
- Image window: h in [X_OFF, X_OFF+511] and v in [Y_OFF, Y_OFF+255].
  - xi = h - X_OFF, yi = v - Y_OFF.
- Stage 1 (registered on tick from counters):
  - vga_word_addr = yi*32 + xi[8:4], i.e. {yi[7:0], xi[8:4]}.
  - Outside the window, vga_word_addr holds its last value; the data is don't-care there.
  - Also registered in stage 1: bit index xi[3:0], in_img, de (h<640 and v<480), hs (h in [656,751]), vs (v in [490,491]), and first (h==0 and v==0).
- RAM: read latency is 1 clock. Because CLK_DIV >= 2, vga_word is stable by the next tick.
- Stage 2 (registered on tick):
  - vga_pixel = in_img_s1 & ~vga_word[bit_s1]. Hack convention: a set bit is black, and bit 0 is the leftmost pixel of the word.
  - vga_de = de_s1, vga_hsync = ~hs_s1, vga_vsync = ~vs_s1.
  - Border (de=1, in_img=0) and blanking (de=0) both drive vga_pixel = 0.
- Latency: every output lags the counters by exactly 2 ticks, and sync, de and pixel stay mutually aligned.
- frame_start: high for exactly one clock, the clock on which stage 2 loads first_s1 = 1. It is low at all other times.
- Reset values:
  - Divider, h, v, vga_word_addr and all stage registers: 0.
  - vga_hsync = 1, vga_vsync = 1, vga_de = 0, vga_pixel = 0, frame_start = 0.
- Reset mid-frame: takes effect on the next clock edge and restarts everything from (0,0). No partial-line state survives.
  - First tick after release: counters advance to h=1.
  - frame_start fires on the 2nd tick after release.
- Port B is read-only from this block. Write enable and write data are tied off at the memory.

Test Plan:
1. Reset held 3 clocks -> vga_hsync=1, vga_vsync=1, vga_de=0, vga_pixel=0, vga_word_addr=0, frame_start=0.
2. Free run, CLK_DIV=2 -> hsync low 192 clocks every 1600; vsync low 3200 clocks every 840000; vga_de high 1280 clocks per visible line; frame_start period 840000.
3. RAM model returning data=addr, address capture:
   - (h=64, v=112) -> addr 0.
   - (h=80, v=112) -> addr 1.
   - (h=64, v=113) -> addr 32.
   - (h=560, v=367) -> addr 8191.
   - Each address is stable for 16 ticks.
4. Bit order and colour:
   - Word 0 = 16'h0001, all other words 0 -> raster pixel (64,112) = 0; pixels 65..79 = 1.
   - Word 0 = 16'h8000 -> pixel 79 = 0; pixels 64..78 = 1.
5. Border, RAM all zeros:
   - Pixels at x=63, x=576, y=111 and y=368 -> 0.
   - Pixel (64,112) -> 1.
   - All blanking pixels -> 0 with vga_de=0.
6. Reset asserted at v=200, h=300 for 1 clock -> outputs return to reset values; frame_start pulses exactly 2 ticks after release; next hsync falls (656+2) ticks after release.
